// File: rtl/btn_pkg.sv
// Shared constants for the push-button conditioner: per-channel FSM state
// encoding and shortened counter lengths for simulation builds.
package btn_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_PRESS_WAIT = 3'd1;
  localparam state_t ST_HELD       = 3'd2;
  localparam state_t ST_LONG_HELD  = 3'd3;
  localparam state_t ST_REL_WAIT   = 3'd4;

  localparam int DBG_DEBOUNCE = 8;
  localparam int DBG_LONG     = 64;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce FSM, debounce and
// hold counters, registered level and event pulses.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level_out,
  output logic press_out,
  output logic release_out,
  output logic long_out
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);

  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  state_t            state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              from_long_q, from_long_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              rel_q, rel_d;
  logic              long_q, long_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      state_q     <= ST_IDLE;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      from_long_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      from_long_q <= from_long_d;
      level_q     <= level_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      long_q      <= long_d;
    end
  end

  // Counters only advance below their terminal value, so neither can wrap.
  always_comb begin
    s1_d        = btn_raw;
    s2_d        = s1_q;
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    from_long_d = from_long_q;
    case (state_q)
      ST_IDLE: begin
        if (s2_q) begin
          state_d  = ST_PRESS_WAIT;
          db_cnt_d = DB_ONE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s2_q) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = ST_HELD;
          db_cnt_d    = '0;
          hold_cnt_d  = '0;
          from_long_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      ST_HELD: begin
        if (!s2_q) begin
          state_d  = ST_REL_WAIT;
          db_cnt_d = DB_ONE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d     = ST_LONG_HELD;
          from_long_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
      ST_LONG_HELD: begin
        if (!s2_q) begin
          state_d  = ST_REL_WAIT;
          db_cnt_d = DB_ONE;
        end
      end
      ST_REL_WAIT: begin
        // A glitch returns to whichever held state was left; no pulses.
        if (s2_q) begin
          state_d  = from_long_q ? ST_LONG_HELD : ST_HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    press_d = (state_q == ST_PRESS_WAIT) && s2_q  && (db_cnt_q == DB_LAST);
    rel_d   = (state_q == ST_REL_WAIT)   && !s2_q && (db_cnt_q == DB_LAST);
    long_d  = (state_q == ST_HELD)       && s2_q  && (hold_cnt_q == HOLD_LAST);
    level_d = level_q;
    if (press_d) begin
      level_d = 1'b1;
    end else if (rel_d) begin
      level_d = 1'b0;
    end
  end

  assign level_out   = level_q;
  assign press_out   = press_q;
  assign release_out = rel_q;
  assign long_out    = long_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: N_BTN independent debounce channels producing a
// clean level plus press, release and long-press pulses per button.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN             = 3,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 100000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn[i]),
      .level_out  (btn_level[i]),
      .press_out  (btn_press[i]),
      .release_out(btn_release[i]),
      .long_out   (btn_long[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: a run-length reference model predicts
// every cycle's outputs, a monitor pops and compares them on the falling edge.
module tb_btn_debounce;

  localparam int N = 3;
  localparam int D = 8;
  localparam int L = 64;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: a level flips once D consecutive synchronised samples
  // disagree with it; hold time counts samples high while already high.
  bit m_s1[N], m_s2[N], m_lvl[N], m_prev[N], m_done[N];
  int m_run[N], m_hold[N];

  btn_debounce #(
    .N_BTN            (N),
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic modelStep(input logic [N-1:0] b, input logic r);
    exp_t e;
    bit   samp;
    e = '0;
    for (int c = 0; c < N; c++) begin
      if (!r) begin
        m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_prev[c] = 0; m_done[c] = 0;
        m_run[c] = 0; m_hold[c] = 0;
      end else begin
        samp = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = b[c];
        if (samp != m_lvl[c]) m_run[c]++;
        else m_run[c] = 0;
        if (m_run[c] == D) begin
          m_lvl[c] = samp;
          m_run[c] = 0;
          if (samp) begin
            e.press[c] = 1'b1;
            m_hold[c] = 0;
            m_done[c] = 0;
          end else begin
            e.rel[c] = 1'b1;
          end
        end else if (m_lvl[c] && samp && m_prev[c] && !m_done[c]) begin
          m_hold[c]++;
          if (m_hold[c] == L) begin
            e.lng[c] = 1'b1;
            m_done[c] = 1;
          end
        end
        m_prev[c] = samp;
      end
      e.level[c] = m_lvl[c];
    end
    exp_q.push_back(e);
  endtask

  // Drives one cycle of inputs mid-low-phase and queues the predicted response.
  task automatic applyStimulus(input logic [N-1:0] b, input logic r);
    @(negedge clk);
    #2;
    btn   = b;
    rst_n = r;
    modelStep(b, r);
  endtask

  task automatic holdFor(input logic [N-1:0] b, input int cycles);
    repeat (cycles) applyStimulus(b, 1'b1);
  endtask

  // Monitor: outputs are valid every cycle, so one expectation is consumed per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("btn_level",   btn_level,   e.level);
        checkOutput("btn_press",   btn_press,   e.press);
        checkOutput("btn_release", btn_release, e.rel);
        checkOutput("btn_long",    btn_long,    e.lng);
      end
    end
  end

  initial begin
    logic [N-1:0] cur;
    int           rem[N];

    repeat (3) applyStimulus(3'b000, 1'b0);
    holdFor(3'b000, 5);

    $display("[TB] clean press/release on btn[0]");
    holdFor(3'b001, 40);
    holdFor(3'b000, 15);

    $display("[TB] bounce rejection on btn[1]");
    for (int i = 0; i < 40; i++) applyStimulus(((i / 3) % 2) ? 3'b010 : 3'b000, 1'b1);
    holdFor(3'b010, 20);
    holdFor(3'b000, 15);

    $display("[TB] long press on btn[2]");
    holdFor(3'b100, 100);
    holdFor(3'b000, 15);

    $display("[TB] release glitch on btn[0]");
    holdFor(3'b001, 20);
    holdFor(3'b000, 5);
    holdFor(3'b001, 80);
    holdFor(3'b000, 15);

    $display("[TB] concurrent presses");
    holdFor(3'b000, 5);
    holdFor(3'b101, 20);
    holdFor(3'b111, 20);
    holdFor(3'b000, 15);

    $display("[TB] reset while all buttons held");
    holdFor(3'b111, 30);
    applyStimulus(3'b111, 1'b0);
    #1;
    checkOutput("async_reset_level", btn_level, 3'b000);
    checkOutput("async_reset_press", btn_press | btn_release | btn_long, 3'b000);
    applyStimulus(3'b111, 1'b0);
    applyStimulus(3'b111, 1'b0);
    holdFor(3'b111, 20);
    holdFor(3'b000, 15);

    $display("[TB] randomized traffic");
    cur = '0;
    for (int c = 0; c < N; c++) rem[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (rem[c] == 0) begin
          cur[c] = 1'($urandom_range(0, 1));
          rem[c] = ($urandom_range(0, 9) < 4) ? int'($urandom_range(1, 5))
                                              : int'($urandom_range(10, 110));
        end
        rem[c]--;
      end
      applyStimulus(cur, !(cyc >= 1500 && cyc < 1503));
    end
    holdFor(3'b000, 15);

    repeat (3) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
